// File: rtl/gs_pkg.sv
// Shared types and constants for the Gauss-Seidel sweep sequencer.
// Widths, fixed-point formats, state enum.
package gs_pkg;

  localparam int N_ROWS  = 8;
  localparam int X_W     = 32;
  localparam int A_W     = 8;
  localparam int ADOWN_W = 32;
  localparam int ROW_W   = 3;
  localparam int IT_W    = 8;
  localparam int AV_W    = (N_ROWS - 1) * A_W;
  localparam int XV_W    = (N_ROWS - 1) * X_W;

  localparam int S7_24_FRAC = 24;
  localparam logic [X_W-1:0] ONE_S7_24 = 32'h0100_0000;
  localparam int S1_30_FRAC = 30;
  localparam logic [ADOWN_W-1:0] ONE_S1_30 = 32'h4000_0000;

  // Early-exit threshold on |x_new - x_old|, S7.24.
  localparam logic [X_W-1:0] CONV_TOL = 32'h0000_0100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DUMP,
    S_DONE
  } state_e;

endpackage

// File: rtl/gs_sweep_ctrl_if.sv
// Bundle of all non-clock signals of gs_sweep_ctrl.
// master = sequencer side, slave = host/memory/core side.
interface gs_sweep_ctrl_if;
  import gs_pkg::*;

  logic               start;
  logic [IT_W-1:0]    iter_num;
  logic               busy;
  logic               done;
  logic               coef_rd;
  logic [ROW_W-1:0]   coef_addr;
  logic [AV_W-1:0]    coef_a;
  logic [A_W-1:0]     coef_b;
  logic [ADOWN_W-1:0] coef_adown;
  logic               core_reset;
  logic               core_valid;
  logic [AV_W-1:0]    core_a;
  logic [A_W-1:0]     core_b;
  logic [ADOWN_W-1:0] core_adown;
  logic [XV_W-1:0]    core_x;
  logic               core_ovalid;
  logic [X_W-1:0]     core_xnext;
  logic               out_valid;
  logic [ROW_W-1:0]   out_idx;
  logic [X_W-1:0]     out_x;

  modport master (
    input  start, iter_num,
    input  coef_a, coef_b, coef_adown,
    input  core_ovalid, core_xnext,
    output busy, done, coef_rd, coef_addr,
    output core_reset, core_valid,
    output core_a, core_b, core_adown, core_x,
    output out_valid, out_idx, out_x
  );

  modport slave (
    output start, iter_num,
    output coef_a, coef_b, coef_adown,
    output core_ovalid, core_xnext,
    input  busy, done, coef_rd, coef_addr,
    input  core_reset, core_valid,
    input  core_a, core_b, core_adown, core_x,
    input  out_valid, out_idx, out_x
  );

endinterface

// File: rtl/gs_xvec_pack.sv
// Builds the 7-entry vector x[j], j != row, ascending j,
// lowest j in the top slice. Ports: x_i, row_i in; xv_o out.
module gs_xvec_pack
  import gs_pkg::*;
(
  input  logic [N_ROWS-1:0][X_W-1:0] x_i,
  input  logic [ROW_W-1:0]           row_i,
  output logic [XV_W-1:0]            xv_o
);

  always_comb begin
    xv_o = '0;
    for (int k = 0; k < N_ROWS - 1; k++) begin
      if (k < int'(row_i))
        xv_o[XV_W-1-k*X_W -: X_W] = x_i[k];
      else
        xv_o[XV_W-1-k*X_W -: X_W] = x_i[k+1];
    end
  end

endmodule

// File: rtl/gs_sweep_ctrl.sv
// Gauss-Seidel sweep sequencer: owns x[0..7], drives the row core,
// streams results. Ports: i_clk, i_reset, bus (gs_sweep_ctrl_if.master).
// Option: GS_CONV_EARLY_EXIT_EN enables convergence early exit.
module gs_sweep_ctrl
  import gs_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  gs_sweep_ctrl_if.master bus
);

  state_e state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [IT_W-1:0] sweep_q, sweep_d;
  logic [IT_W-1:0] iter_q, iter_d;
  logic [ROW_W-1:0] cnt_q, cnt_d;
  logic [N_ROWS-1:0][X_W-1:0] x_q, x_d;
  logic [AV_W-1:0] a_q, a_d;
  logic [A_W-1:0] b_q, b_d;
  logic [ADOWN_W-1:0] ad_q, ad_d;
  logic [XV_W-1:0] xv_q, xv_d;
  logic [XV_W-1:0] xv;
  logic early;

  gs_xvec_pack u_pack (
    .x_i   (x_q),
    .row_i (row_q),
    .xv_o  (xv)
  );

`ifdef GS_CONV_EARLY_EXIT_EN
  logic conv_q, conv_d;
  logic signed [X_W:0] diff;
  logic [X_W:0] mag;
  logic row_ok;

  // conv_q: every row so far in this sweep moved less than CONV_TOL
  always_comb begin
    diff = $signed({bus.core_xnext[X_W-1], bus.core_xnext})
         - $signed({x_q[row_q][X_W-1], x_q[row_q]});
    mag = diff[X_W] ? $unsigned(-diff) : $unsigned(diff);
    row_ok = mag < {1'b0, CONV_TOL};
    early = conv_q & row_ok & (sweep_q != '0);
    conv_d = conv_q;
    if (state_q == S_IDLE)
      conv_d = 1'b1;
    else if (state_q == S_WAIT && bus.core_ovalid)
      conv_d = (row_q == ROW_W'(N_ROWS - 1))
             ? 1'b1 : (conv_q & row_ok);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) conv_q <= 1'b1;
    else         conv_q <= conv_d;
  end
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    sweep_d = sweep_q;
    iter_d  = iter_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    a_d     = a_q;
    b_d     = b_q;
    ad_d    = ad_q;
    xv_d    = xv_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          x_d     = '0;
          iter_d  = bus.iter_num;
          row_d   = '0;
          sweep_d = '0;
          cnt_d   = '0;
          state_d = (bus.iter_num == '0) ? S_DUMP : S_CLR;
        end
      end
      S_CLR:   state_d = S_FETCH;
      S_FETCH: begin
        a_d     = bus.coef_a;
        b_d     = bus.coef_b;
        ad_d    = bus.coef_adown;
        xv_d    = xv;
        state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.core_ovalid) begin
          x_d[row_q] = bus.core_xnext;
          if (row_q != ROW_W'(N_ROWS - 1)) begin
            row_d   = row_q + 1'b1;
            state_d = S_CLR;
          end else begin
            row_d   = '0;
            sweep_d = sweep_q + 1'b1;
            if (sweep_q + 1'b1 == iter_q || early)
              state_d = S_DUMP;
            else
              state_d = S_CLR;
          end
        end
      end
      S_DUMP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ROW_W'(N_ROWS - 1))
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      sweep_q <= '0;
      iter_q  <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ad_q    <= '0;
      xv_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      sweep_q <= sweep_d;
      iter_q  <= iter_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ad_q    <= ad_d;
      xv_q    <= xv_d;
    end
  end

  logic in_dump;
  assign in_dump = (state_q == S_DUMP);

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.coef_rd    = (state_q == S_CLR);
  assign bus.coef_addr  = (state_q == S_CLR) ? row_q : '0;
  assign bus.core_reset = (state_q == S_IDLE) || (state_q == S_CLR)
                       || in_dump || (state_q == S_DONE);
  assign bus.core_valid = (state_q == S_ISSUE);
  assign bus.core_a     = a_q;
  assign bus.core_b     = b_q;
  assign bus.core_adown = ad_q;
  assign bus.core_x     = xv_q;
  assign bus.out_valid  = in_dump;
  assign bus.out_idx    = in_dump ? cnt_q : '0;
  assign bus.out_x      = in_dump ? x_q[cnt_q] : '0;

endmodule

// File: tb/tb_gs_sweep_ctrl.sv
// Self-checking bench for gs_sweep_ctrl: coefficient memory, core model,
// Gauss-Seidel reference and per-cycle schedule comparison.
module tb_gs_sweep_ctrl;
  import gs_pkg::*;

`ifdef GS_CONV_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gs_sweep_ctrl_if bus ();

  gs_sweep_ctrl dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  int cur_k  = 0;

  logic [55:0] mem_a [8];
  logic [7:0]  mem_b [8];
  logic [31:0] mem_ad [8];

  logic [31:0]  m_x [8];
  logic [223:0] m_corex [$];
  int           m_sweeps;

  logic [31:0]  dut_out [8];
  logic [223:0] cx_row1;
  int           done_k;

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got=%0h want=%0h", nm, cur_k, act, exp);
    end
  endtask

  // Row core: xnext = ((b<<24) - sum a_k*x_k) * adown >> 30
  function automatic logic [31:0] core_fn(input logic [55:0] a,
                                          input logic [7:0] b,
                                          input logic [31:0] ad,
                                          input logic [223:0] xv);
    logic signed [95:0] acc;
    logic signed [95:0] prod;
    logic [7:0] ak;
    logic [31:0] xk;
    acc = $signed({{88{b[7]}}, b}) <<< 24;
    for (int k = 0; k < 7; k++) begin
      ak = a[55-8*k -: 8];
      xk = xv[223-32*k -: 32];
      acc = acc - $signed({{88{ak[7]}}, ak})
                * $signed({{64{xk[31]}}, xk});
    end
    prod = acc * $signed({{64{ad[31]}}, ad});
    prod = prod >>> 30;
    return prod[31:0];
  endfunction

  logic [2:0]  vpipe;
  logic [31:0] pend_x;

  always @(posedge clk) begin
    if (rst) begin
      vpipe           <= '0;
      pend_x          <= '0;
      bus.core_ovalid <= 1'b0;
      bus.core_xnext  <= '0;
    end else begin
      vpipe           <= {vpipe[1:0], bus.core_valid};
      bus.core_ovalid <= vpipe[2];
      bus.core_xnext  <= vpipe[2] ? pend_x : 32'h0;
      if (bus.core_valid)
        pend_x <= core_fn(bus.core_a, bus.core_b,
                          bus.core_adown, bus.core_x);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      bus.coef_a     <= '0;
      bus.coef_b     <= '0;
      bus.coef_adown <= '0;
    end else if (bus.coef_rd) begin
      bus.coef_a     <= mem_a[bus.coef_addr];
      bus.coef_b     <= mem_b[bus.coef_addr];
      bus.coef_adown <= mem_ad[bus.coef_addr];
    end
  end

  // Reference Gauss-Seidel solve over the bench coefficient memory.
  task automatic model_solve(input int n);
    logic [223:0] v;
    logic [31:0] nx;
    longint d;
    bit conv;
    int j;
    for (int i = 0; i < 8; i++) m_x[i] = '0;
    m_corex.delete();
    m_sweeps = 0;
    for (int sw = 0; sw < n; sw++) begin
      conv = 1'b1;
      for (int r = 0; r < 8; r++) begin
        v = '0;
        for (int k = 0; k < 7; k++) begin
          j = (k >= r) ? k + 1 : k;
          v[223-32*k -: 32] = m_x[j];
        end
        m_corex.push_back(v);
        nx = core_fn(mem_a[r], mem_b[r], mem_ad[r], v);
        d = longint'($signed(nx)) - longint'($signed(m_x[r]));
        if (d < 0) d = -d;
        if (d >= longint'(CONV_TOL)) conv = 1'b0;
        m_x[r] = nx;
      end
      m_sweeps++;
      if (EARLY && sw > 0 && conv) break;
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_coef_rd", bus.coef_rd, 0);
    chk("rst_coef_addr", bus.coef_addr, 0);
    chk("rst_core_valid", bus.core_valid, 0);
    chk("rst_core_a", bus.core_a, 0);
    chk("rst_core_b", bus.core_b, 0);
    chk("rst_core_adown", bus.core_adown, 0);
    chk("rst_core_x", bus.core_x, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_idx", bus.out_idx, 0);
    chk("rst_out_x", bus.out_x, 0);
    chk("rst_core_reset", bus.core_reset, 1);
  endtask

  // Expected outputs k cycles after the cycle start was sampled.
  task automatic check_cycle(input int k, input int s);
    int base;
    int p;
    int idx;
    int r;
    int i;
    base = 56 * s;
    if (k <= base) begin
      p   = (k - 1) % 7;
      idx = (k - 1) / 7;
      r   = idx % 8;
      chk("busy", bus.busy, 1);
      chk("coef_rd", bus.coef_rd, p == 0);
      if (p == 0) chk("coef_addr", bus.coef_addr, r);
      chk("core_valid", bus.core_valid, p == 2);
      chk("core_reset", bus.core_reset, p == 0);
      chk("out_valid", bus.out_valid, 0);
      chk("done", bus.done, 0);
      if (p >= 2) begin
        chk("core_x", bus.core_x, m_corex[idx]);
        chk("core_a", bus.core_a, mem_a[r]);
        chk("core_b", bus.core_b, mem_b[r]);
        chk("core_adown", bus.core_adown, mem_ad[r]);
      end
      if (idx == 1 && p == 2) cx_row1 = bus.core_x;
    end else if (k <= base + 8) begin
      i = k - base - 1;
      chk("dump_valid", bus.out_valid, 1);
      chk("dump_idx", bus.out_idx, i);
      chk("dump_x", bus.out_x, m_x[i]);
      chk("dump_busy", bus.busy, 1);
      chk("dump_core_reset", bus.core_reset, 1);
      chk("dump_coef_rd", bus.coef_rd, 0);
      chk("dump_done", bus.done, 0);
      dut_out[i] = bus.out_x;
    end else if (k == base + 9) begin
      chk("done_pulse", bus.done, 1);
      chk("done_busy", bus.busy, 1);
      chk("done_out_valid", bus.out_valid, 0);
      chk("done_core_reset", bus.core_reset, 1);
    end else begin
      chk("idle_busy", bus.busy, 0);
      chk("idle_done", bus.done, 0);
      chk("idle_core_reset", bus.core_reset, 1);
      chk("idle_coef_rd", bus.coef_rd, 0);
    end
    if (bus.done) done_k = k;
  endtask

  task automatic run(input int n, input bit pulse, input int abort_k);
    int total;
    model_solve(n);
    total = 56 * m_sweeps + 9;
    done_k = -1;
    for (int i = 0; i < 8; i++) dut_out[i] = 32'hDEAD_BEEF;
    cx_row1 = '0;
    bus.iter_num = 8'(n);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= total + 1; k++) begin
      cur_k = k;
      check_cycle(k, m_sweeps);
      if (k == abort_k) begin
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        @(negedge clk);
        return;
      end
      bus.start = 1'b0;
      if (pulse && (k == 10 || k == 40 || k == 56 * m_sweeps + 5)) begin
        bus.start = 1'b1;
        bus.iter_num = 8'($urandom);
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic set_diag();
    for (int i = 0; i < 8; i++) begin
      mem_a[i]  = '0;
      mem_b[i]  = 8'(i + 1);
      mem_ad[i] = ONE_S1_30;
    end
  endtask

  task automatic set_rowdep();
    for (int i = 0; i < 8; i++) begin
      mem_a[i]  = '0;
      mem_b[i]  = '0;
      mem_ad[i] = ONE_S1_30;
    end
    mem_b[0] = 8'd2;
    mem_b[1] = 8'd5;
    mem_a[1] = {8'd1, 48'd0};
  endtask

  task automatic set_rand();
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 7; k++)
        mem_a[i][8*k +: 8] = 8'($urandom_range(0, 4)) - 8'd2;
      mem_b[i]  = 8'($urandom);
      mem_ad[i] = 32'($urandom_range(32'h0800_0000, 32'h4000_0000));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.iter_num = '0;
    set_diag();
    repeat (3) @(negedge clk);
    cur_k = 0;
    chk_reset_vals();
    rst = 1'b0;
    @(negedge clk);

    set_diag();
    run(1, 1'b0, 0);
    chk("diag_x2", dut_out[2], 32'h0300_0000);
    chk("diag_x7", dut_out[7], 32'h0800_0000);
    chk("diag_done_cycle", done_k, 65);

    set_rowdep();
    run(1, 1'b0, 0);
    chk("rowdep_x0", dut_out[0], 32'h0200_0000);
    chk("rowdep_x1", dut_out[1], 32'h0300_0000);
    chk("rowdep_corex", cx_row1[223:192], 32'h0200_0000);

    set_rand();
    run(0, 1'b0, 0);
    chk("zero_x3", dut_out[3], 32'h0);
    chk("zero_done_cycle", done_k, 9);

    set_diag();
    run(3, 1'b0, 82);
    run(1, 1'b0, 0);
    chk("post_rst_x2", dut_out[2], 32'h0300_0000);
    chk("post_rst_done", done_k, 65);

    repeat (3) begin
      set_rand();
      run($urandom_range(1, 3), 1'b1, 0);
    end

    set_diag();
    run(10, 1'b0, 0);
    chk("iter10_done_cycle", done_k, EARLY ? 121 : 569);
    chk("iter10_x4", dut_out[4], 32'h0500_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout k=%0d", cur_k);
    $fatal(1, "timeout");
  end

endmodule
